// File: rtl/pico_bridge_pkg.sv
// Shared types for the pico memory bridge: FSM states, error causes and the
// strobe-width helper used by the bridge and its optional timeout counter.
package pico_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_DONE = 2'd3
  } bridge_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_SLAVE   = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_cause_e;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int STRB_WIDTH         = DEFAULT_DATA_WIDTH / 8;

  // One strobe bit per byte lane.
  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/pico_bridge_timeout.sv
// Outstanding-transaction watchdog for the pico memory bridge. Only
// instantiated when PICO_BRIDGE_TIMEOUT_EN is defined.
module pico_bridge_timeout
  import pico_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic busy_i,
  output logic expired_o
);

  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  // Restart on entry to REQ, count while outstanding, saturate at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (busy_i && (cnt_q != LastCnt)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The cycle holding the last count is the TIMEOUT_CYCLES-th outstanding one.
  assign expired_o = busy_i && (cnt_q == LastCnt);

endmodule

// File: rtl/pico_mem_bridge.sv
// Bridge from a PicoRV32-style native memory interface to separate
// instruction and data MEM master ports (req/gnt, then valid/rdata/error).
// One transaction in flight at a time. Optional watchdog is enabled with
// the PICO_BRIDGE_TIMEOUT_EN macro.
module pico_mem_bridge
  import pico_bridge_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    lite_valid_i,
  input  logic                    lite_instr_i,
  input  logic [ADDR_WIDTH-1:0]   lite_addr_i,
  input  logic [DATA_WIDTH-1:0]   lite_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] lite_wstrb_i,
  output logic                    lite_ready_o,
  output logic [DATA_WIDTH-1:0]   lite_rdata_o,
  output logic                    instr_mem_req_o,
  output logic [ADDR_WIDTH-1:0]   instr_mem_addr_o,
  input  logic                    instr_mem_gnt_i,
  input  logic                    instr_mem_valid_i,
  input  logic [DATA_WIDTH-1:0]   instr_mem_rdata_i,
  input  logic                    instr_mem_error_i,
  output logic                    data_mem_req_o,
  output logic [ADDR_WIDTH-1:0]   data_mem_addr_o,
  output logic                    data_mem_we_o,
  output logic [DATA_WIDTH/8-1:0] data_mem_be_o,
  output logic [DATA_WIDTH-1:0]   data_mem_wdata_o,
  input  logic                    data_mem_gnt_i,
  input  logic                    data_mem_valid_i,
  input  logic [DATA_WIDTH-1:0]   data_mem_rdata_i,
  input  logic                    data_mem_error_i,
  output logic                    bus_err_o,
  output logic [1:0]              err_cause_o,
  output logic [ADDR_WIDTH-1:0]   err_addr_o,
  input  logic                    err_clr_i
);

  localparam int StrbW = strb_width(DATA_WIDTH);

  if (((DATA_WIDTH % 8) != 0) || (StrbW < 1) || (TIMEOUT_CYCLES < 1)) begin : g_bad_param
    $error("pico_mem_bridge: DATA_WIDTH must be a positive multiple of 8 and TIMEOUT_CYCLES >= 1");
  end

  bridge_state_e          state_q;
  logic                   instr_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   ireq_q;
  logic [ADDR_WIDTH-1:0]  iaddr_q;
  logic                   dreq_q;
  logic [ADDR_WIDTH-1:0]  daddr_q;
  logic                   dwe_q;
  logic [StrbW-1:0]       dbe_q;
  logic [DATA_WIDTH-1:0]  dwdata_q;
  logic                   ready_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   bus_err_q;
  err_cause_e             err_cause_q;
  logic [ADDR_WIDTH-1:0]  err_addr_q;

  logic                   sel_gnt;
  logic                   sel_valid;
  logic                   sel_err;
  logic [DATA_WIDTH-1:0]  sel_rdata;
  logic                   in_req;
  logic                   in_rsp;
  logic                   accept;
  logic                   to_expired;
  logic                   timeout_hit;
  logic                   new_err;

  // Response path of whichever port the latched request targets.
  assign sel_gnt   = instr_q ? instr_mem_gnt_i   : data_mem_gnt_i;
  assign sel_valid = instr_q ? instr_mem_valid_i : data_mem_valid_i;
  assign sel_err   = instr_q ? instr_mem_error_i : data_mem_error_i;
  assign sel_rdata = instr_q ? instr_mem_rdata_i : data_mem_rdata_i;

  assign in_req = (state_q == ST_REQ);
  assign in_rsp = (state_q == ST_RSP);

  // A response counts only while outstanding; in REQ it also needs the grant.
  assign accept      = (in_req && sel_gnt && sel_valid) || (in_rsp && sel_valid);
  assign timeout_hit = to_expired && !accept;
  assign new_err     = (accept && sel_err) || timeout_hit;

`ifdef PICO_BRIDGE_TIMEOUT_EN
  pico_bridge_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   ((state_q == ST_IDLE) && lite_valid_i),
    .busy_i    (in_req || in_rsp),
    .expired_o (to_expired)
  );
`else
  assign to_expired = 1'b0;
`endif

  // Transaction FSM; every MEM-side and lite-side output is a register here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      instr_q  <= 1'b0;
      addr_q   <= '0;
      ireq_q   <= 1'b0;
      iaddr_q  <= '0;
      dreq_q   <= 1'b0;
      daddr_q  <= '0;
      dwe_q    <= 1'b0;
      dbe_q    <= '0;
      dwdata_q <= '0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (lite_valid_i) begin
            state_q <= ST_REQ;
            instr_q <= lite_instr_i;
            addr_q  <= lite_addr_i;
            if (lite_instr_i) begin
              ireq_q  <= 1'b1;
              iaddr_q <= lite_addr_i;
            end else begin
              dreq_q   <= 1'b1;
              daddr_q  <= lite_addr_i;
              dwe_q    <= |lite_wstrb_i;
              dbe_q    <= lite_wstrb_i;
              dwdata_q <= lite_wdata_i;
            end
          end
        end
        ST_REQ, ST_RSP: begin
          if (accept || timeout_hit) begin
            state_q <= ST_DONE;
            ready_q <= 1'b1;
            rdata_q <= (accept && !sel_err) ? sel_rdata : '0;
          end else if (in_req && sel_gnt) begin
            state_q <= ST_RSP;
          end
          // Request fields only live for the REQ phase.
          if (accept || timeout_hit || (in_req && sel_gnt)) begin
            ireq_q   <= 1'b0;
            iaddr_q  <= '0;
            dreq_q   <= 1'b0;
            daddr_q  <= '0;
            dwe_q    <= 1'b0;
            dbe_q    <= '0;
            dwdata_q <= '0;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky first-error record; a fresh error beats a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus_err_q   <= 1'b0;
      err_cause_q <= ERR_NONE;
      err_addr_q  <= '0;
    end else if (new_err && (!bus_err_q || err_clr_i)) begin
      bus_err_q  <= 1'b1;
      err_addr_q <= addr_q;
      if (timeout_hit) begin
        err_cause_q <= ERR_TIMEOUT;
      end else begin
        err_cause_q <= ERR_SLAVE;
      end
    end else if (err_clr_i) begin
      bus_err_q   <= 1'b0;
      err_cause_q <= ERR_NONE;
      err_addr_q  <= '0;
    end
  end

  assign lite_ready_o     = ready_q;
  assign lite_rdata_o     = rdata_q;
  assign instr_mem_req_o  = ireq_q;
  assign instr_mem_addr_o = iaddr_q;
  assign data_mem_req_o   = dreq_q;
  assign data_mem_addr_o  = daddr_q;
  assign data_mem_we_o    = dwe_q;
  assign data_mem_be_o    = dbe_q;
  assign data_mem_wdata_o = dwdata_q;
  assign bus_err_o        = bus_err_q;
  assign err_cause_o      = err_cause_q;
  assign err_addr_o       = err_addr_q;

endmodule
